// File: rtl/dvp_cap_pkg.sv
// Shared definitions for the DVP RGB565 capture path: FSM encoding,
// default frame geometry and RGB565 field positions.
package dvp_cap_pkg;

  typedef enum logic [1:0] {
    S_SYNC = 2'd0,
    S_VS   = 2'd1,
    S_CAP  = 2'd2,
    S_DONE = 2'd3
  } cap_state_e;

  // Default geometry matches the LCD panel timing.
  localparam int unsigned DEF_H_ACTIVE = 480;
  localparam int unsigned DEF_V_ACTIVE = 272;

  // RGB565 field positions within the 16-bit word.
  localparam int unsigned R_MSB = 15;
  localparam int unsigned R_LSB = 11;
  localparam int unsigned G_MSB = 10;
  localparam int unsigned G_LSB = 5;
  localparam int unsigned B_MSB = 4;
  localparam int unsigned B_LSB = 0;

endpackage

// File: rtl/rgb565_pack.sv
// Packs a byte stream into 16-bit RGB565 words: first byte is the high byte.
module rgb565_pack
  import dvp_cap_pkg::*;
(
  input  logic        clk,
  input  logic        i_rst_n,
  input  logic        i_clr,
  input  logic        i_vld,
  input  logic [7:0]  i_byte,
  output logic [15:0] o_word,
  output logic        o_vld,
  output logic        o_phase,
  output logic        o_done
);

  logic        r_phase;
  logic [7:0]  r_hi;
  logic [15:0] r_word;
  logic        r_vld;
  logic [15:0] w_word;

  // A word completes on the second byte of a pair.
  assign o_done  = i_vld & r_phase;
  assign o_word  = r_word;
  assign o_vld   = r_vld;
  assign o_phase = r_phase;

  // Scatter the byte pair into the RGB565 fields.
  always_comb begin
    w_word                = '0;
    w_word[R_MSB:R_LSB]   = r_hi[7:3];
    w_word[G_MSB:G_LSB]   = {r_hi[2:0], i_byte[7:5]};
    w_word[B_MSB:B_LSB]   = i_byte[4:0];
  end

  // Byte phase, high-byte latch and registered word/valid.
  always_ff @(posedge clk) begin
    if (!i_rst_n) begin
      r_phase <= 1'b0;
      r_hi    <= 8'h00;
      r_word  <= 16'h0000;
      r_vld   <= 1'b0;
    end else begin
      r_vld <= o_done;
      if (o_done) r_word <= w_word;
      if (i_vld && !r_phase) r_hi <= i_byte;
      if (i_clr) r_phase <= 1'b0;
      else if (i_vld) r_phase <= ~r_phase;
    end
  end

endmodule

// File: rtl/dvp_rgb565_capture.sv
// DVP camera stream to RGB565 FIFO writer with frame framing and error flags.
module dvp_rgb565_capture
  import dvp_cap_pkg::*;
#(
  parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
  parameter int unsigned V_ACTIVE = DEF_V_ACTIVE
) (
  input  logic        clk,
  input  logic        i_rst_n,
  input  logic        i_cap_en,
  input  logic        i_clr_err,
  input  logic        i_vsync,
  input  logic        i_href,
  input  logic [7:0]  i_data,
  input  logic        i_fifo_full,
  output logic        o_fifo_wr_en,
  output logic [15:0] o_fifo_wr_data,
  output logic        o_fifo_rec_work_en,
  output logic        o_frame_done,
  output logic [7:0]  o_frame_cnt,
  output logic        o_line_err,
  output logic        o_ovf
);

  localparam int unsigned PW = $clog2(H_ACTIVE + 1);
  localparam int unsigned LW = $clog2(V_ACTIVE + 1);
  localparam logic [PW-1:0] H_END = PW'(H_ACTIVE);
  localparam logic [LW-1:0] V_END = LW'(V_ACTIVE);

  cap_state_e    r_state;
  logic          r_vs;
  logic          r_href;
  logic [PW-1:0] r_pix;
  logic [LW-1:0] r_line;
  logic          r_pending_vs;
  logic          r_wr_ok;
  logic          r_rec_en;
  logic          r_frame_done;
  logic [7:0]    r_frame_cnt;
  logic          r_line_err;
  logic          r_ovf;

  logic          w_vs_rise;
  logic          w_vs_fall;
  logic          w_href_fall;
  logic          w_cap;
  logic          w_pack_vld;
  logic          w_pack_clr;
  logic [15:0]   w_pack_word;
  logic          w_pack_wvld;
  logic          w_pack_phase;
  logic          w_word_done;
  logic          w_pix_room;
  logic [LW-1:0] w_line_inc;
  logic          w_line_last;
  logic          w_short;
  logic          w_set_line_err;
  logic          w_set_ovf;

  assign w_vs_rise   = i_vsync & ~r_vs;
  assign w_vs_fall   = ~i_vsync & r_vs;
  assign w_href_fall = ~i_href & r_href;
  assign w_cap       = (r_state == S_CAP);
  assign w_pack_vld  = i_href & w_cap;
  assign w_pack_clr  = ((r_state == S_VS) & w_vs_fall) | (w_cap & w_href_fall);

  rgb565_pack u_pack (
    .clk     (clk),
    .i_rst_n (i_rst_n),
    .i_clr   (w_pack_clr),
    .i_vld   (w_pack_vld),
    .i_byte  (i_data),
    .o_word  (w_pack_word),
    .o_vld   (w_pack_wvld),
    .o_phase (w_pack_phase),
    .o_done  (w_word_done)
  );

  assign w_pix_room  = (r_pix < H_END);
  assign w_line_inc  = r_line + 1'b1;
  // Line closes before the short-frame check, so a vsync on the final
  // href_fall is a complete frame, not a short one.
  assign w_line_last = w_href_fall & (w_line_inc == V_END);
  assign w_short     = w_vs_rise & ~w_line_last;

  assign w_set_line_err = w_cap & ((w_word_done & ~w_pix_room) |
                                   (w_href_fall & ((r_pix != H_END) | w_pack_phase)) |
                                   w_short);
  assign w_set_ovf      = w_cap & w_word_done & w_pix_room & i_fifo_full;

  assign o_fifo_wr_en       = w_pack_wvld & r_wr_ok;
  assign o_fifo_wr_data     = w_pack_word;
  assign o_fifo_rec_work_en = r_rec_en;
  assign o_frame_done       = r_frame_done;
  assign o_frame_cnt        = r_frame_cnt;
  assign o_line_err         = r_line_err;
  assign o_ovf              = r_ovf;

  // Frame FSM, geometry counters, sticky flags and registered outputs.
  always_ff @(posedge clk) begin
    if (!i_rst_n) begin
      r_state      <= S_SYNC;
      r_vs         <= 1'b0;
      r_href       <= 1'b0;
      r_pix        <= '0;
      r_line       <= '0;
      r_pending_vs <= 1'b0;
      r_wr_ok      <= 1'b0;
      r_rec_en     <= 1'b0;
      r_frame_done <= 1'b0;
      r_frame_cnt  <= 8'h00;
      r_line_err   <= 1'b0;
      r_ovf        <= 1'b0;
    end else begin
      r_vs         <= i_vsync;
      r_href       <= i_href;
      r_frame_done <= 1'b0;
      // Pixel counter advances even on overflow so geometry stays aligned.
      r_wr_ok      <= w_cap & w_word_done & w_pix_room & ~i_fifo_full;

      // Set has priority over clear.
      if (w_set_line_err)  r_line_err <= 1'b1;
      else if (i_clr_err)  r_line_err <= 1'b0;
      if (w_set_ovf)       r_ovf <= 1'b1;
      else if (i_clr_err)  r_ovf <= 1'b0;

      case (r_state)
        S_SYNC: begin
          if (w_vs_rise && i_cap_en) r_state <= S_VS;
        end
        S_VS: begin
          if (w_vs_fall) begin
            r_state  <= S_CAP;
            r_rec_en <= 1'b1;
            r_pix    <= '0;
            r_line   <= '0;
          end
        end
        S_CAP: begin
          if (w_word_done && w_pix_room) r_pix <= r_pix + 1'b1;
          if (w_href_fall) begin
            r_pix  <= '0;
            r_line <= w_line_inc;
          end
          if (w_line_last || w_vs_rise) begin
            r_state      <= S_DONE;
            r_rec_en     <= 1'b0;
            r_frame_done <= 1'b1;
            r_frame_cnt  <= r_frame_cnt + 8'd1;
            // Remember the vsync so the next frame is not missed.
            r_pending_vs <= w_vs_rise;
          end
        end
        S_DONE: begin
          r_pending_vs <= 1'b0;
          r_state      <= (r_pending_vs && i_cap_en) ? S_VS : S_SYNC;
        end
        default: r_state <= S_SYNC;
      endcase
    end
  end

endmodule

// File: tb/tb_dvp_rgb565_capture.sv
// Self-checking bench for dvp_rgb565_capture with a 4x2 frame geometry.
module tb_dvp_rgb565_capture;

  localparam int H = 4;
  localparam int V = 2;

  logic        clk;
  logic        i_rst_n;
  logic        i_cap_en;
  logic        i_clr_err;
  logic        i_vsync;
  logic        i_href;
  logic [7:0]  i_data;
  logic        i_fifo_full;
  logic        o_fifo_wr_en;
  logic [15:0] o_fifo_wr_data;
  logic        o_fifo_rec_work_en;
  logic        o_frame_done;
  logic [7:0]  o_frame_cnt;
  logic        o_line_err;
  logic        o_ovf;

  int n_checks = 0;
  int n_fail   = 0;
  int n_wr     = 0;
  int n_done   = 0;
  logic [15:0] exp_q[$];

  dvp_rgb565_capture #(
    .H_ACTIVE (H),
    .V_ACTIVE (V)
  ) dut (
    .clk                (clk),
    .i_rst_n            (i_rst_n),
    .i_cap_en           (i_cap_en),
    .i_clr_err          (i_clr_err),
    .i_vsync            (i_vsync),
    .i_href             (i_href),
    .i_data             (i_data),
    .i_fifo_full        (i_fifo_full),
    .o_fifo_wr_en       (o_fifo_wr_en),
    .o_fifo_wr_data     (o_fifo_wr_data),
    .o_fifo_rec_work_en (o_fifo_rec_work_en),
    .o_frame_done       (o_frame_done),
    .o_frame_cnt        (o_frame_cnt),
    .o_line_err         (o_line_err),
    .o_ovf              (o_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Write monitor: pops the scoreboard on every FIFO write.
  always @(negedge clk) begin
    logic [15:0] exp_w;
    if (o_fifo_wr_en === 1'b1) begin
      n_wr++;
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_write: got %h, required no write", o_fifo_wr_data);
      end else begin
        exp_w = exp_q.pop_front();
        if (o_fifo_wr_data !== exp_w) begin
          n_fail++;
          $display("FAIL wr_data: got %h, required %h", o_fifo_wr_data, exp_w);
        end
      end
      n_checks++;
      if (o_fifo_rec_work_en !== 1'b1) begin
        n_fail++;
        $display("FAIL rec_en_during_write: got %b, required 1", o_fifo_rec_work_en);
      end
    end
    if (o_frame_done === 1'b1) n_done++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Vsync pulse of two cycles; rec_en must follow vs_fall by one cycle.
  task automatic vsync_pulse(input logic cap);
    i_cap_en = cap;
    i_vsync  = 1'b1;
    tick();
    tick();
    n_checks++;
    if (o_fifo_rec_work_en !== 1'b0) begin
      n_fail++;
      $display("FAIL rec_en_before_vs_fall: got %b, required 0", o_fifo_rec_work_en);
    end
    i_vsync = 1'b0;
    tick();
    n_checks++;
    if (o_fifo_rec_work_en !== cap) begin
      n_fail++;
      $display("FAIL rec_en_after_vs_fall: got %b, required %b", o_fifo_rec_work_en, cap);
    end
    tick();
    tick();
  endtask

  // One line of nb bytes base, base+1, ...; word full_k sees a full FIFO.
  task automatic send_line(input int nb, input logic [7:0] base, input int full_k,
                           input bit cap, input bit chk_end);
    logic [7:0] hi;
    hi = 8'h00;
    for (int b = 0; b < nb; b++) begin
      i_href      = 1'b1;
      i_data      = base + 8'(b);
      i_fifo_full = ((b % 2) == 1) && ((b / 2) == full_k);
      if ((b % 2) == 0) hi = i_data;
      else if (cap && (b / 2) < H && (b / 2) != full_k) exp_q.push_back({hi, i_data});
      tick();
    end
    i_href      = 1'b0;
    i_fifo_full = 1'b0;
    if (chk_end) begin
      n_checks++;
      if (o_fifo_wr_en !== 1'b1) begin
        n_fail++;
        $display("FAIL last_write_timing: got wr_en %b, required 1", o_fifo_wr_en);
      end
    end
    tick();
    if (chk_end) begin
      n_checks++;
      if (o_frame_done !== 1'b1 || o_fifo_rec_work_en !== 1'b0) begin
        n_fail++;
        $display("FAIL frame_end: got done %b rec_en %b, required done 1 rec_en 0",
                 o_frame_done, o_fifo_rec_work_en);
      end
    end
    tick();
    if (chk_end) begin
      n_checks++;
      if (o_frame_done !== 1'b0) begin
        n_fail++;
        $display("FAIL done_pulse_width: got %b, required 0", o_frame_done);
      end
    end
    tick();
  endtask

  task automatic clear_err();
    i_clr_err = 1'b1;
    tick();
    i_clr_err = 1'b0;
    n_checks++;
    if (o_line_err !== 1'b0 || o_ovf !== 1'b0) begin
      n_fail++;
      $display("FAIL clr_err: got line_err %b ovf %b, required 0 0", o_line_err, o_ovf);
    end
  endtask

  task automatic check_all_zero(input string name);
    n_checks++;
    if ({o_fifo_wr_en, o_fifo_wr_data, o_fifo_rec_work_en, o_frame_done, o_frame_cnt,
         o_line_err, o_ovf} !== 29'd0) begin
      n_fail++;
      $display("FAIL %s: got wr %b data %h rec %b done %b cnt %0d lerr %b ovf %b, required all 0",
               name, o_fifo_wr_en, o_fifo_wr_data, o_fifo_rec_work_en, o_frame_done,
               o_frame_cnt, o_line_err, o_ovf);
    end
  endtask

  task automatic check_frame(input string name, input int wr0, input int wr_exp,
                             input int done0, input int done_exp, input logic [7:0] cnt,
                             input logic lerr, input logic ovf);
    n_checks++;
    if ((n_wr - wr0) != wr_exp || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL %s_writes: got %0d (left %0d), required %0d (left 0)",
               name, n_wr - wr0, exp_q.size(), wr_exp);
    end
    n_checks++;
    if ((n_done - done0) != done_exp || o_frame_cnt !== cnt) begin
      n_fail++;
      $display("FAIL %s_frames: got done %0d cnt %0d, required done %0d cnt %0d",
               name, n_done - done0, o_frame_cnt, done_exp, cnt);
    end
    n_checks++;
    if (o_line_err !== lerr || o_ovf !== ovf) begin
      n_fail++;
      $display("FAIL %s_flags: got line_err %b ovf %b, required %b %b",
               name, o_line_err, o_ovf, lerr, ovf);
    end
    exp_q.delete();
  endtask

  task automatic test_reset();
    i_rst_n = 1'b0;
    tick();
    tick();
    tick();
    check_all_zero("reset");
    i_rst_n = 1'b1;
    tick();
  endtask

  task automatic test_nominal();
    int wr0 = n_wr;
    int d0  = n_done;
    vsync_pulse(1'b1);
    send_line(2 * H, 8'h00, -1, 1'b1, 1'b0);
    n_checks++;
    if (o_fifo_rec_work_en !== 1'b1) begin
      n_fail++;
      $display("FAIL rec_en_between_lines: got %b, required 1", o_fifo_rec_work_en);
    end
    send_line(2 * H, 8'h00, -1, 1'b1, 1'b1);
    check_frame("nominal", wr0, 8, d0, 1, 8'd1, 1'b0, 1'b0);
  endtask

  task automatic test_disabled();
    int wr0 = n_wr;
    int d0  = n_done;
    vsync_pulse(1'b0);
    send_line(2 * H, 8'h40, -1, 1'b0, 1'b0);
    send_line(2 * H, 8'h48, -1, 1'b0, 1'b0);
    n_checks++;
    if (o_fifo_rec_work_en !== 1'b0) begin
      n_fail++;
      $display("FAIL disabled_rec_en: got %b, required 0", o_fifo_rec_work_en);
    end
    check_frame("disabled", wr0, 0, d0, 0, 8'd1, 1'b0, 1'b0);
  endtask

  task automatic test_geometry();
    int wr0 = n_wr;
    int d0  = n_done;
    vsync_pulse(1'b1);
    send_line(7, 8'h50, -1, 1'b1, 1'b0);
    n_checks++;
    if (o_line_err !== 1'b1 || (n_wr - wr0) != 3) begin
      n_fail++;
      $display("FAIL short_line: got line_err %b writes %0d, required 1 3",
               o_line_err, n_wr - wr0);
    end
    send_line(10, 8'h60, -1, 1'b1, 1'b0);
    check_frame("geometry", wr0, 7, d0, 1, 8'd2, 1'b1, 1'b0);
    clear_err();
  endtask

  task automatic test_overflow();
    int wr0 = n_wr;
    int d0  = n_done;
    vsync_pulse(1'b1);
    send_line(2 * H, 8'h10, 1, 1'b1, 1'b0);
    send_line(2 * H, 8'h20, -1, 1'b1, 1'b1);
    check_frame("overflow", wr0, 7, d0, 1, 8'd3, 1'b0, 1'b1);
    clear_err();
  endtask

  task automatic test_short_frame();
    int wr0 = n_wr;
    int d0  = n_done;
    vsync_pulse(1'b1);
    send_line(2 * H, 8'h30, -1, 1'b1, 1'b0);
    vsync_pulse(1'b1);
    check_frame("short", wr0, 4, d0, 1, 8'd4, 1'b1, 1'b0);
    wr0 = n_wr;
    d0  = n_done;
    send_line(2 * H, 8'h70, -1, 1'b1, 1'b0);
    send_line(2 * H, 8'h78, -1, 1'b1, 1'b1);
    check_frame("after_short", wr0, 8, d0, 1, 8'd5, 1'b1, 1'b0);
    clear_err();
  endtask

  task automatic test_reset_mid();
    int d0;
    int wr0;
    vsync_pulse(1'b1);
    for (int b = 0; b < 5; b++) begin
      i_href = 1'b1;
      i_data = 8'h90 + 8'(b);
      if (b == 1) exp_q.push_back(16'h9091);
      if (b == 3) exp_q.push_back(16'h9293);
      tick();
    end
    d0      = n_done;
    i_rst_n = 1'b0;
    tick();
    check_all_zero("reset_mid");
    i_href  = 1'b0;
    i_rst_n = 1'b1;
    tick();
    tick();
    n_checks++;
    if (n_done != d0 || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL reset_mid_done: got done %0d left %0d, required 0 0",
               n_done - d0, exp_q.size());
    end
    exp_q.delete();
    wr0 = n_wr;
    d0  = n_done;
    vsync_pulse(1'b1);
    send_line(2 * H, 8'hA0, -1, 1'b1, 1'b0);
    send_line(2 * H, 8'hB0, -1, 1'b1, 1'b1);
    check_frame("after_reset", wr0, 8, d0, 1, 8'd1, 1'b0, 1'b0);
  endtask

  initial begin
    i_rst_n     = 1'b0;
    i_cap_en    = 1'b0;
    i_clr_err   = 1'b0;
    i_vsync     = 1'b0;
    i_href      = 1'b0;
    i_data      = 8'h00;
    i_fifo_full = 1'b0;
    test_reset();
    test_nominal();
    test_disabled();
    test_geometry();
    test_overflow();
    test_short_frame();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
